// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction fetch, one-entry skid buffer and IF/ID register.
// Optional FETCH_STAGE_PERF_EN adds the perf_fetched counter of instructions entering IF/ID.
module fetch_stage #(
   parameter int ADDR_W = 32,
   parameter int INSTR_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int PC_INCR = 4,
   parameter logic [INSTR_W-1:0] BUBBLE = 32'hC000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [1:0]         instruction_type,
   output logic [4:0]         func
`ifdef FETCH_STAGE_PERF_EN
   ,
   output logic [31:0]        perf_fetched
`endif
);
   typedef enum logic [1:0] {BOOT, FETCH, HELD} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx, if_pc_nx, skid_pc, skid_pc_nx;
   logic [INSTR_W-1:0] if_instr_nx, skid_instr, skid_instr_nx;
   logic if_valid_nx;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= BOOT;
         pc <= RESET_PC;
         if_valid <= 1'b0;
         if_instr <= BUBBLE;
         if_pc <= '0;
         skid_instr <= '0;
         skid_pc <= '0;
      end else begin
         state <= state_nx;
         pc <= pc_nx;
         if_valid <= if_valid_nx;
         if_instr <= if_instr_nx;
         if_pc <= if_pc_nx;
         skid_instr <= skid_instr_nx;
         skid_pc <= skid_pc_nx;
      end
   always_comb
      state_nx = state == BOOT  ? FETCH :
                 state == FETCH ? ((!redirect && stall && imem_ready) ? HELD : FETCH) :
                 state == HELD  ? ((redirect || !stall) ? FETCH : HELD) : BOOT;
   // Skid only fills while stalled, so its pc always equals the held pc.
   always_comb begin
      pc_nx = pc;
      if_valid_nx = if_valid;
      if_instr_nx = if_instr;
      if_pc_nx = if_pc;
      skid_instr_nx = skid_instr;
      skid_pc_nx = skid_pc;
      if (state == FETCH) begin
         if (redirect) begin
            pc_nx = redirect_pc;
            if_valid_nx = 1'b0;
            if_instr_nx = BUBBLE;
            if_pc_nx = '0;
         end else if (stall) begin
            if (imem_ready) begin
               skid_instr_nx = imem_rdata;
               skid_pc_nx = pc;
            end
         end else if (imem_ready) begin
            if_valid_nx = 1'b1;
            if_instr_nx = imem_rdata;
            if_pc_nx = pc;
            pc_nx = pc + ADDR_W'(PC_INCR);
         end else begin
            if_valid_nx = 1'b0;
            if_instr_nx = BUBBLE;
            if_pc_nx = '0;
         end
      end else if (state == HELD) begin
         if (redirect) begin
            pc_nx = redirect_pc;
            if_valid_nx = 1'b0;
            if_instr_nx = BUBBLE;
            if_pc_nx = '0;
         end else if (!stall) begin
            if_valid_nx = 1'b1;
            if_instr_nx = skid_instr;
            if_pc_nx = skid_pc;
            pc_nx = pc + ADDR_W'(PC_INCR);
         end
      end
   end
   assign imem_req = state == FETCH;
   assign imem_addr = pc;
   assign instruction_type = if_instr[INSTR_W-1 -: 2];
   assign func = if_instr[INSTR_W-3 -: 5];
`ifdef FETCH_STAGE_PERF_EN
   logic accept;
   assign accept = !redirect && !stall && ((state == FETCH && imem_ready) || state == HELD);
   always_ff @(posedge clk or posedge rst)
      if (rst) perf_fetched <= '0;
      else if (accept) perf_fetched <= perf_fetched + 32'd1;
`endif
endmodule
